// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } gnt_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that pulses expire for one cycle when the loaded latency has elapsed.
module mem_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             expire
);

  logic [LAT_W-1:0] cnt;
  logic             active;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - LAT_W'(1);
    end
  end

  assign expire = active && (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory port and drives the core stall.
// Optional build macro ARB_PERF_CNT_EN adds saturating per-requester stall counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       dm_stall_cnt
`endif
);

  localparam int LAT_LOAD = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

  state_t            state;
  gnt_t              last_gnt;   // doubles as the grant of the transaction in flight
  logic              lat_we;
  logic [DATA_W-1:0] rdata_q;
  logic              pick_dm;
  logic              start;
  logic              lat_expire;

  // On a tie the requester that did not win last time goes first.
  assign pick_dm = dm_req && (!if_req || (last_gnt == GNT_IF));
  assign start   = (state == IDLE) && (if_req || dm_req);

  mem_lat_counter u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (LAT_W'(LAT_LOAD)),
    .expire   (lat_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_gnt  <= GNT_DM;
      lat_we    <= 1'b0;
      rdata_q   <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      // NOTE: pulse outputs get a default every cycle so no branch can leave them stuck high.
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= BUSY;
            mem_en <= 1'b1;
            if (pick_dm) begin
              last_gnt  <= GNT_DM;
              lat_we    <= dm_we;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_be    <= dm_be;
            end else begin
              last_gnt  <= GNT_IF;
              lat_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= 4'hF;
            end
          end
        end
        BUSY: begin
          if (lat_expire) begin
            state   <= DONE;
            rdata_q <= lat_we ? '0 : mem_rdata;
            if (last_gnt == GNT_DM) dm_ready <= 1'b1;
            else                    if_ready <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign if_rdata = if_ready ? rdata_q : '0;
  assign dm_rdata = dm_ready ? rdata_q : '0;
  assign stall    = (if_req && !if_ready) || (dm_req && !dm_ready);

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if_stall_cnt <= '0;
      dm_stall_cnt <= '0;
    end else begin
      if (if_req && !if_ready && (if_stall_cnt != '1)) if_stall_cnt <= if_stall_cnt + 32'd1;
      if (dm_req && !dm_ready && (dm_stall_cnt != '1)) dm_stall_cnt <= dm_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
